// File: rtl/operand_entry.sv
// Calculator front-panel controller: debounced buttons drive operand editing, a 5-state FSM and the ALU start pulse.
// Optional auto-repeat on held up/down is enabled by defining OPERAND_ENTRY_AUTOREPEAT_EN.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  input  logic        result_valid,
  output logic [15:0] operandA,
  output logic [15:0] operandB,
  output logic [1:0]  chosen_operand,
  output logic [1:0]  display_mode,
  output logic [1:0]  digit_sel,
  output logic        start,
  output logic        busy
);

  localparam int NB = 5;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Bit index doubles as priority: lowest index wins.
  localparam int B_CENTER = 0;
  localparam int B_UP     = 1;
  localparam int B_DOWN   = 2;
  localparam int B_LEFT   = 3;
  localparam int B_RIGHT  = 4;

  typedef enum logic [2:0] {IDLE, ENTER_A, ENTER_B, COMPUTE, SHOW_RESULT} state_t;

  state_t          state, state_nx;
  logic [NB-1:0]   raw, sync1, sync2, level, level_q, press, rpt_vec, events, win;
  logic [CW-1:0]   db_cnt [NB];

  assign raw = {btn_right, btn_left, btn_down, btn_up, btn_center};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press  = level & ~level_q;
  assign events = press | rpt_vec;
  assign win    = events & (~events + 5'd1);

`ifdef OPERAND_ENTRY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_cnt;
  logic          rpt_armed, held, rpt_fire;

  assign held     = level[B_UP] | level[B_DOWN];
  // Count starts at the press cycle; reload to 1 so later repeats land exactly REPEAT_PERIOD apart.
  assign rpt_fire = held && (rpt_cnt == (rpt_armed ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
  assign rpt_vec  = !rpt_fire     ? '0 :
                    level[B_UP]   ? NB'(1 << B_UP) : NB'(1 << B_DOWN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (!held || state_nx != state) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= RW'(1);
      rpt_armed <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt + RW'(1);
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > REPEAT_PERIOD);
  assign rpt_vec = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_nx       = state;
    display_mode   = 2'b00;
    chosen_operand = 2'b00;
    busy           = 1'b0;
    unique case (state)
      IDLE: if (win[B_CENTER]) state_nx = ENTER_A;
      ENTER_A: begin
        display_mode   = 2'b01;
        chosen_operand = 2'b01;
        if (win[B_CENTER]) state_nx = ENTER_B;
      end
      ENTER_B: begin
        display_mode   = 2'b01;
        chosen_operand = 2'b10;
        if (win[B_CENTER]) state_nx = COMPUTE;
      end
      COMPUTE: begin
        display_mode   = 2'b01;
        chosen_operand = 2'b10;
        busy           = 1'b1;
        if (result_valid) state_nx = SHOW_RESULT;
      end
      SHOW_RESULT: begin
        display_mode = 2'b10;
        if (win[B_CENTER]) state_nx = ENTER_A;
      end
      default: state_nx = IDLE;
    endcase
  end

  function automatic logic [15:0] step_nibble(input logic [15:0] v, input logic [1:0] d,
                                              input logic down);
    logic [15:0] r;
    r = v;
    r[{d, 2'b00} +: 4] = down ? v[{d, 2'b00} +: 4] - 4'd1 : v[{d, 2'b00} +: 4] + 4'd1;
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operandA  <= '0;
      operandB  <= '0;
      digit_sel <= '0;
      start     <= 1'b0;
    end else begin
      start <= (state == ENTER_B) && win[B_CENTER];
      if (state == SHOW_RESULT && win[B_CENTER]) begin
        operandA  <= '0;
        operandB  <= '0;
        digit_sel <= '0;
      end else if (state == ENTER_A && win[B_CENTER]) begin
        digit_sel <= '0;
      end else if (state == ENTER_A || state == ENTER_B) begin
        if (win[B_UP] || win[B_DOWN]) begin
          if (state == ENTER_A) operandA <= step_nibble(operandA, digit_sel, win[B_DOWN]);
          else                  operandB <= step_nibble(operandB, digit_sel, win[B_DOWN]);
        end else if (win[B_LEFT]) begin
          digit_sel <= digit_sel + 2'd1;
        end else if (win[B_RIGHT]) begin
          digit_sel <= digit_sel - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed scenarios, then random button presses against a
// behavioural model of the calculator front panel.
module tb_operand_entry;

  localparam int HOLD = 8;
  localparam int M_IDLE = 0, M_A = 1, M_B = 2, M_COMP = 3, M_SHOW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  btn;  // {right, left, down, up, center}
  logic        result_valid;
  logic [15:0] operandA, operandB;
  logic [1:0]  chosen_operand, display_mode, digit_sel;
  logic        start, busy;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_state;
  logic [15:0] m_a, m_b;
  int          m_dig;

  operand_entry #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn[1]), .btn_down(btn[2]), .btn_left(btn[3]), .btn_right(btn[4]),
    .btn_center(btn[0]), .result_valid(result_valid),
    .operandA(operandA), .operandB(operandB), .chosen_operand(chosen_operand),
    .display_mode(display_mode), .digit_sel(digit_sel), .start(start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] nib_step(input logic [15:0] v, input int d, input int delta);
    int vi, n;
    vi = v;
    n  = ((vi >> (4 * d)) & 15);
    n  = (n + delta + 16) % 16;
    vi = (vi & ~(15 << (4 * d))) | (n << (4 * d));
    return vi[15:0];
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE; m_a = 0; m_b = 0; m_dig = 0;
  endfunction

  // Winner is the lowest-numbered button in the mask (center highest priority).
  function automatic void model_press(input logic [4:0] mask);
    int b;
    b = -1;
    for (int i = 4; i >= 0; i--) if (mask[i]) b = i;
    case (m_state)
      M_IDLE: if (b == 0) m_state = M_A;
      M_A, M_B: begin
        if (b == 0) begin
          if (m_state == M_A) begin m_state = M_B; m_dig = 0; end
          else m_state = M_COMP;
        end else if (b == 1 || b == 2) begin
          if (m_state == M_A) m_a = nib_step(m_a, m_dig, (b == 1) ? 1 : -1);
          else                m_b = nib_step(m_b, m_dig, (b == 1) ? 1 : -1);
        end else if (b == 3) m_dig = (m_dig + 1) % 4;
        else if (b == 4)     m_dig = (m_dig + 3) % 4;
      end
      M_SHOW: if (b == 0) begin m_state = M_A; m_a = 0; m_b = 0; m_dig = 0; end
      default: ;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".opA"},   operandA, m_a);
    check({tag, ".opB"},   operandB, m_b);
    check({tag, ".digit"}, {14'd0, digit_sel}, 16'(m_dig));
    check({tag, ".mode"},  {14'd0, display_mode},
          (m_state == M_IDLE) ? 16'd0 : (m_state == M_SHOW) ? 16'd2 : 16'd1);
    check({tag, ".chosen"}, {14'd0, chosen_operand},
          (m_state == M_A) ? 16'd1 : (m_state == M_B || m_state == M_COMP) ? 16'd2 : 16'd0);
    check({tag, ".busy"},  {15'd0, busy},  (m_state == M_COMP) ? 16'd1 : 16'd0);
    check({tag, ".start"}, {15'd0, start}, 16'd0);
  endtask

  task automatic press(input logic [4:0] mask);
    btn = mask;
    tick(HOLD);
    btn = '0;
    tick(HOLD);
    model_press(mask);
  endtask

  initial begin
    int exp_up;
    btn = '0; result_valid = 1'b0; reset = 1'b1;
    model_reset();
    tick(3);
    check_all("reset");
    reset = 1'b0;

    // Bouncing center, then steady: exactly one transition, 7 cycles after steady start.
    for (int i = 0; i < 8; i++) begin btn[0] = (i % 4) < 2; tick(1); end
    btn[0] = 1'b1;
    tick(6);
    check("bounce.early_mode", {14'd0, display_mode}, 16'd0);
    tick(1);
    check("bounce.mode", {14'd0, display_mode}, 16'd1);
    check("bounce.chosen", {14'd0, chosen_operand}, 16'd1);
    tick(3);
    btn = '0;
    tick(HOLD);
    model_press(5'b00001);
    check_all("bounce.after");

    // Edit A: 3x up, left, down wraps nibble 1 to F.
    repeat (3) press(5'b00010);
    press(5'b01000);
    press(5'b00100);
    check("editA.const", operandA, 16'h00F3);
    check_all("editA");

    // A -> B, right twice wraps digit 0 -> 3 -> 2, up.
    press(5'b00001);
    press(5'b10000);
    press(5'b10000);
    press(5'b00010);
    check("editB.const", operandB, 16'h0100);
    check_all("editB");

    // Start pulse is exactly one cycle; buttons ignored in COMPUTE.
    btn = 5'b00001;
    tick(6);
    check("start.before", {15'd0, start}, 16'd0);
    tick(1);
    check("start.pulse", {15'd0, start}, 16'd1);
    check("start.busy", {15'd0, busy}, 16'd1);
    tick(1);
    check("start.after", {15'd0, start}, 16'd0);
    tick(6);
    btn = '0;
    tick(HOLD);
    model_press(5'b00001);
    press(5'b00010);
    press(5'b01000);
    check_all("compute.ignore");
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    m_state = M_SHOW;
    check_all("show");
    press(5'b00001);
    check_all("show.clear");

    // Up and left together: only the increment acts.
    press(5'b01010);
    check_all("prio.up_left");

    // result_valid already high when start fires is accepted.
    press(5'b00001);
    btn = 5'b00001; result_valid = 1'b1;
    tick(7);
    check("rv_same.start", {15'd0, start}, 16'd1);
    tick(1);
    check("rv_same.mode", {14'd0, display_mode}, 16'd2);
    check("rv_same.busy", {15'd0, busy}, 16'd0);
    result_valid = 1'b0; btn = '0;
    tick(HOLD);
    m_state = M_SHOW;
    check_all("rv_same");
    press(5'b00001);
    press(5'b00001);
    press(5'b00001);
    check_all("pre_reset");

    // Asynchronous reset in COMPUTE.
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    for (int i = 0; i < 3; i++) begin tick(1); check("reset.start", {15'd0, start}, 16'd0); end
    reset = 1'b0;
    tick(2);
    check_all("post_reset");

    // Held up: 40 cycles of accepted level.
    press(5'b00001);
    btn = 5'b00010;
    tick(40);
    btn = '0;
    tick(HOLD);
`ifdef OPERAND_ENTRY_AUTOREPEAT_EN
    exp_up = 5;
`else
    exp_up = 1;
`endif
    for (int i = 0; i < exp_up; i++) m_a = nib_step(m_a, m_dig, 1);
    check_all("hold_up");

    // Random presses and result_valid pulses against the model.
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 9) begin
        result_valid = 1'b1;
        tick(1);
        result_valid = 1'b0;
        tick(1);
        if (m_state == M_COMP) m_state = M_SHOW;
      end else if (r == 8) begin
        press(5'($urandom_range(1, 31)));
      end else begin
        press(5'(1 << $urandom_range(0, 4)));
      end
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
